tl_packet_source: RTL and testbench

- Transmit-side packet source for the PCIe transaction layer: accepts class/destination/payload requests from the application side and writes 12-bit words into the transaction-layer input FIFO.
- Builds each word as {class[1:0], dest[1:0], payload[7:0]}; the layout matches what the demuxes decode (bits 11:10 class, bits 9:8 destination).
- Holds words in a small internal staging queue.
- Obeys the FIFO's almost-full backpressure and the init phase of the layer state machine.

---
 rtl/tl_packet_source_if.sv | 39 +++
 rtl/tl_packet_source.sv | 140 ++++++++++++++
 tb/tb_tl_packet_source.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_packet_source_if.sv
// ----------------------------------------------------------------------------
// tl_packet_source_if
//   Bundles the application request handshake and the transaction-layer input
//   FIFO write port used by tl_packet_source.
//
//   Signals:
//     req_valid     application request present
//     req_ready     packet source can accept a request this cycle
//     req_class     traffic class         -> word[11:10]
//     req_dest      destination port      -> word[9:8]
//     req_payload   payload byte          -> word[7:0]
//     fifo_alm_full almost-full from the layer input FIFO
//     fifo_push     registered push strobe into the layer input FIFO
//     fifo_data     registered 12-bit word into the layer input FIFO
//
//   Modports:
//     slave  - the packet source itself
//     master - its environment (application side plus the FIFO's status)
// ----------------------------------------------------------------------------
interface tl_packet_source_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_class;
    logic [1:0]  req_dest;
    logic [7:0]  req_payload;
    logic        fifo_alm_full;
    logic        fifo_push;
    logic [11:0] fifo_data;

    modport slave (
        input  req_valid, req_class, req_dest, req_payload, fifo_alm_full,
        output req_ready, fifo_push, fifo_data
    );

    modport master (
        output req_valid, req_class, req_dest, req_payload, fifo_alm_full,
        input  req_ready, fifo_push, fifo_data
    );
endinterface

// File: rtl/tl_packet_source.sv
// ----------------------------------------------------------------------------
// tl_packet_source
//   Transmit-side packet source for the PCIe transaction layer. Requests are
//   packed as {class, dest, payload} into a DEPTH-entry staging queue and
//   drained one word per cycle into the layer input FIFO, honouring the FIFO's
//   almost-full flag and the layer's init phase.
//
//   Ports:
//     clk         rising-edge clock
//     reset_L     asynchronous active-low reset (flushes the staging queue)
//     init        layer in init/threshold-load phase; no pushes while high
//     bus         tl_packet_source_if.slave (request handshake + FIFO port)
//     sent_count  number of words pushed, wraps modulo 2^CNT_W
//     idle        nothing queued and nothing in flight
//
//   Build option:
//     TL_SRC_PARITY_EN - when defined, word[7] carries even parity over
//                        word[11:8] and word[6:0]; req_payload[7] is ignored.
// ----------------------------------------------------------------------------
module tl_packet_source #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    tl_packet_source_if.slave    bus,
    output logic [CNT_W-1:0]     sent_count,
    output logic                 idle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

`ifdef TL_SRC_PARITY_EN
    // Bit 7 becomes the even-parity bit over the other eleven bits.
    function automatic logic [11:0] apply_parity(input logic [11:0] w);
        logic [11:0] r;
        r    = w;
        r[7] = ^{w[11:8], w[6:0]};
        return r;
    endfunction
`endif

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     occ, occ_nxt;
    logic [11:0]        queue_mem [DEPTH];
    logic [11:0]        word_in;
    logic               enq, deq, blocked;
    logic               push_q;
    logic [11:0]        data_q;

    // Input stage: pack request fields into the outgoing word layout.
`ifdef TL_SRC_PARITY_EN
    assign word_in = apply_parity({bus.req_class, bus.req_dest, bus.req_payload});
`else
    assign word_in = {bus.req_class, bus.req_dest, bus.req_payload};
`endif

    // Ready depends only on occupancy, so a same-cycle dequeue never frees a
    // slot for an enqueue while full.
    assign bus.req_ready = (occ != FULL_OCC);
    assign blocked       = bus.fifo_alm_full || init;
    assign enq           = bus.req_valid && bus.req_ready;
    assign deq           = (occ != '0) && !blocked;
    assign occ_nxt       = occ + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};

    // Staging queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (enq)
            queue_mem[wr_ptr] <= word_in;
    end

    // Queue pointers, occupancy and state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            state  <= IDLE;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ   <= occ_nxt;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (occ_nxt != '0)
                    state_nxt = blocked ? HOLD : SEND;
            end
            SEND: begin
                if (occ_nxt == '0)
                    state_nxt = IDLE;
                else if (blocked)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (occ_nxt == '0)
                    state_nxt = IDLE;
                else if (!blocked)
                    state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage: registered push strobe, data and sent counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_q     <= 1'b0;
            data_q     <= '0;
            sent_count <= '0;
        end else begin
            push_q <= deq;
            if (deq) begin
                data_q     <= queue_mem[rd_ptr];
                sent_count <= sent_count + CNT_W'(1);
            end
        end
    end

    assign bus.fifo_push = push_q;
    assign bus.fifo_data = data_q;
    assign idle          = (state == IDLE) && (occ == '0) && !push_q;

endmodule

// File: tb/tb_tl_packet_source.sv
module tb_tl_packet_source;
    logic       clk;
    logic       reset_L;
    logic       init;
    logic [4:0] sent_count;
    logic       idle;
    int         checks;
    int         errors;

    tl_packet_source_if bus ();

    tl_packet_source #(.DEPTH(4), .PTR_W(2), .CNT_W(5)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .init       (init),
        .bus        (bus.slave),
        .sent_count (sent_count),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] c, input logic [1:0] d, input logic [7:0] p);
        bus.req_class   = c;
        bus.req_dest    = d;
        bus.req_payload = p;
    endtask

    // Expected word for a request (parity applied when the option is built in).
    function automatic logic [11:0] word(input logic [1:0] c, input logic [1:0] d, input logic [7:0] p);
        logic [11:0] r;
        r = {c, d, p};
`ifdef TL_SRC_PARITY_EN
        r[7] = ^{r[11:8], r[6:0]};
`endif
        return r;
    endfunction

    logic [11:0] exp_w [5];

    initial begin
        checks = 0;
        errors = 0;
        reset_L = 1'b0;
        init = 1'b0;
        bus.req_valid = 1'b0;
        bus.fifo_alm_full = 1'b0;
        set_req(2'd0, 2'd0, 8'h00);

        // Reset state
        tick();
        tick();
        check("rst_push", {31'd0, bus.fifo_push}, 32'd0);
        check("rst_data", {20'd0, bus.fifo_data}, 32'd0);
        check("rst_count", {27'd0, sent_count}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_idle", {31'd0, idle}, 32'd1);
        #2 reset_L = 1'b1;
        tick();

        // Single request, one-cycle latency
        set_req(2'd2, 2'd1, 8'hA5);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("single_nopush_yet", {31'd0, bus.fifo_push}, 32'd0);
        check("single_busy", {31'd0, idle}, 32'd0);
        tick();
        check("single_push", {31'd0, bus.fifo_push}, 32'd1);
        check("single_data", {20'd0, bus.fifo_data}, 32'h9A5);
        check("single_count", {27'd0, sent_count}, 32'd1);
        tick();
        check("single_push_off", {31'd0, bus.fifo_push}, 32'd0);
        check("single_count_hold", {27'd0, sent_count}, 32'd1);
        check("single_idle", {31'd0, idle}, 32'd1);
        check("single_data_hold", {20'd0, bus.fifo_data}, 32'h9A5);

        // init blocks pushes, not enqueues
        init = 1'b1;
        exp_w[0] = word(2'd0, 2'd3, 8'h11);
        exp_w[1] = word(2'd1, 2'd2, 8'h22);
        exp_w[2] = word(2'd3, 2'd0, 8'h33);
        set_req(2'd0, 2'd3, 8'h11); bus.req_valid = 1'b1;
        check("init_ready0", {31'd0, bus.req_ready}, 32'd1);
        tick();
        set_req(2'd1, 2'd2, 8'h22);
        check("init_ready1", {31'd0, bus.req_ready}, 32'd1);
        tick();
        set_req(2'd3, 2'd0, 8'h33);
        check("init_ready2", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check("init_ready3", {31'd0, bus.req_ready}, 32'd1);
        check("init_nopush", {31'd0, bus.fifo_push}, 32'd0);
        tick();
        check("init_nopush2", {31'd0, bus.fifo_push}, 32'd0);
        init = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("init_drain_push", {31'd0, bus.fifo_push}, 32'd1);
            check("init_drain_data", {20'd0, bus.fifo_data}, {20'd0, exp_w[i]});
        end
        check("init_count", {27'd0, sent_count}, 32'd4);
        tick();
        check("init_done_push", {31'd0, bus.fifo_push}, 32'd0);
        check("init_done_idle", {31'd0, idle}, 32'd1);

        // alm_full: queue fills at 4, fifth waits for the first dequeue
        bus.fifo_alm_full = 1'b1;
        for (int i = 0; i < 5; i++)
            exp_w[i] = word(2'(i), 2'(3 - i), 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) begin
            set_req(2'(i), 2'(3 - i), 8'(8'h40 + i));
            bus.req_valid = 1'b1;
            check("af_ready", {31'd0, bus.req_ready}, 32'd1);
            tick();
            check("af_nopush", {31'd0, bus.fifo_push}, 32'd0);
        end
        set_req(2'd0, 2'd3, 8'h44);
        check("af_full_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("af_full_ready_hold", {31'd0, bus.req_ready}, 32'd0);
        check("af_full_nopush", {31'd0, bus.fifo_push}, 32'd0);
        bus.fifo_alm_full = 1'b0;
        tick();
        check("af_first_push", {31'd0, bus.fifo_push}, 32'd1);
        check("af_first_data", {20'd0, bus.fifo_data}, {20'd0, exp_w[0]});
        check("af_ready_after_deq", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            if (i > 1) tick();
            check("af_drain_push", {31'd0, bus.fifo_push}, 32'd1);
            check("af_drain_data", {20'd0, bus.fifo_data}, {20'd0, exp_w[i]});
        end
        tick();
        check("af_end_push", {31'd0, bus.fifo_push}, 32'd0);
        check("af_count", {27'd0, sent_count}, 32'd9);

        // One-cycle alm_full pulse mid-burst: exactly one bubble
        bus.fifo_alm_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w[i] = word(2'd1, 2'(i), 8'(8'h60 + i));
            set_req(2'd1, 2'(i), 8'(8'h60 + i));
            bus.req_valid = 1'b1;
            tick();
        end
        bus.req_valid = 1'b0;
        bus.fifo_alm_full = 1'b0;
        tick();
        check("bub_w0_push", {31'd0, bus.fifo_push}, 32'd1);
        check("bub_w0_data", {20'd0, bus.fifo_data}, {20'd0, exp_w[0]});
        bus.fifo_alm_full = 1'b1;
        tick();
        bus.fifo_alm_full = 1'b0;
        check("bub_gap", {31'd0, bus.fifo_push}, 32'd0);
        check("bub_gap_data_hold", {20'd0, bus.fifo_data}, {20'd0, exp_w[0]});
        for (int i = 1; i < 4; i++) begin
            tick();
            check("bub_push", {31'd0, bus.fifo_push}, 32'd1);
            check("bub_data", {20'd0, bus.fifo_data}, {20'd0, exp_w[i]});
        end
        tick();
        check("bub_end_push", {31'd0, bus.fifo_push}, 32'd0);
        check("bub_count", {27'd0, sent_count}, 32'd13);

        // Reset mid-operation flushes the queue
        bus.fifo_alm_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(2'd2, 2'd2, 8'(8'h70 + i));
            bus.req_valid = 1'b1;
            tick();
        end
        bus.req_valid = 1'b0;
        bus.fifo_alm_full = 1'b0;
        tick();
        check("mid_push_before_rst", {31'd0, bus.fifo_push}, 32'd1);
        check("mid_count_before_rst", {27'd0, sent_count}, 32'd14);
        #2 reset_L = 1'b0;
        #1;
        check("mid_rst_push", {31'd0, bus.fifo_push}, 32'd0);
        check("mid_rst_count", {27'd0, sent_count}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_nopush", {31'd0, bus.fifo_push}, 32'd0);
            check("post_rst_idle", {31'd0, idle}, 32'd1);
        end
        check("post_rst_count", {27'd0, sent_count}, 32'd0);

        // 33 back-to-back pushes: counter wraps to 1
        for (int i = 0; i < 33; i++) begin
            set_req(2'd0, 2'd0, 8'(i));
            bus.req_valid = 1'b1;
            tick();
            if (i > 0) begin
                check("wrap_push", {31'd0, bus.fifo_push}, 32'd1);
                check("wrap_data", {20'd0, bus.fifo_data}, {20'd0, word(2'd0, 2'd0, 8'(i - 1))});
            end
        end
        bus.req_valid = 1'b0;
        tick();
        check("wrap_last_push", {31'd0, bus.fifo_push}, 32'd1);
        check("wrap_last_data", {20'd0, bus.fifo_data}, {20'd0, word(2'd0, 2'd0, 8'h20)});
        check("wrap_count", {27'd0, sent_count}, 32'd1);
        tick();
        check("wrap_idle", {31'd0, idle}, 32'd1);

        // Parity word: class=1, dest=0, payload=0
        set_req(2'd1, 2'd0, 8'h00);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("par_push", {31'd0, bus.fifo_push}, 32'd1);
`ifdef TL_SRC_PARITY_EN
        check("par_data", {20'd0, bus.fifo_data}, 32'h480);
`else
        check("par_data", {20'd0, bus.fifo_data}, 32'h400);
`endif
        check("par_count", {27'd0, sent_count}, 32'd2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
